// File: rtl/pfb_32_frame_buffer.sv
// Ping-pong frame buffer: collects one 32-channel I/Q frame (index 31..0) and replays it
// back-to-back into the FFT. Optional macro PFB_32_FRAME_BUFFER_BIT_REVERSE_EN selects bit-reversed read order.
module pfb_32_frame_buffer #(
    parameter int DATA_WIDTH = 15
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Input_valid,
    input  logic [4:0]                   Input_index,
    input  logic signed [DATA_WIDTH-1:0] Input_i,
    input  logic signed [DATA_WIDTH-1:0] Input_q,
    output logic                         Output_valid,
    output logic                         Output_last,
    output logic [4:0]                   Output_index,
    output logic signed [DATA_WIDTH-1:0] Output_i,
    output logic signed [DATA_WIDTH-1:0] Output_q,
    output logic                         Error_overflow,
    output logic                         Error_index_sequence
);

    localparam int EW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {W_SYNC, W_FILL, W_DROP} wr_state_t;
    typedef enum logic {R_IDLE, R_READ} rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;
    logic [4:0] exp_q, exp_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;
    logic [4:0] rd_addr_q, rd_addr_d;
    logic       s1_valid_q, s1_valid_d;
    logic       s1_last_q, s1_last_d;
    logic [4:0] s1_index_q, s1_index_d;
    logic       out_valid_q, out_valid_d;
    logic       out_last_q, out_last_d;
    logic [4:0] out_index_q, out_index_d;
    logic [DATA_WIDTH-1:0] out_i_q, out_i_d;
    logic [DATA_WIDTH-1:0] out_q_q, out_q_d;
    logic       ovf_q, ovf_d;
    logic       seq_q, seq_d;

    logic       wr_en, set_full, clr_full, rd_issue, start_frame;
    logic [4:0] rd_index;

    logic [EW-1:0] mem [0:63];
    logic [EW-1:0] ram_rdata_q;

`ifdef PFB_32_FRAME_BUFFER_BIT_REVERSE_EN
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_rev
            assign rd_index[gi] = rd_addr_q[4-gi];
        end
    endgenerate
`else
    assign rd_index = rd_addr_q;
`endif

    // Writer: tracks the expected descending index; any mismatch resyncs on the next index 31.
    always_comb begin
        wr_state_d  = wr_state_q;
        exp_d       = exp_q;
        wr_bank_d   = wr_bank_q;
        wr_en       = 1'b0;
        set_full    = 1'b0;
        ovf_d       = 1'b0;
        seq_d       = 1'b0;
        start_frame = 1'b0;
        if (Input_valid) begin
            case (wr_state_q)
                W_SYNC: begin
                    if (Input_index == 5'd31) start_frame = 1'b1;
                    else                      seq_d       = 1'b1;
                end
                W_FILL: begin
                    if (Input_index == exp_q) begin
                        wr_en = 1'b1;
                        if (Input_index == 5'd0) begin
                            set_full   = 1'b1;
                            wr_bank_d  = ~wr_bank_q;
                            wr_state_d = W_SYNC;
                        end else begin
                            exp_d = exp_q - 5'd1;
                        end
                    end else begin
                        seq_d = 1'b1;
                        if (Input_index == 5'd31) start_frame = 1'b1;
                        else                      wr_state_d  = W_SYNC;
                    end
                end
                W_DROP: begin
                    if (Input_index == exp_q) begin
                        if (Input_index == 5'd0) wr_state_d = W_SYNC;
                        else                     exp_d      = exp_q - 5'd1;
                    end else begin
                        seq_d = 1'b1;
                        if (Input_index == 5'd31) start_frame = 1'b1;
                        else                      wr_state_d  = W_SYNC;
                    end
                end
                default: wr_state_d = W_SYNC;
            endcase
            if (start_frame) begin
                exp_d = 5'd30;
                if (full_q[wr_bank_q]) begin
                    ovf_d      = 1'b1;
                    wr_state_d = W_DROP;
                end else begin
                    wr_en      = 1'b1;
                    wr_state_d = W_FILL;
                end
            end
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_bank_d  = rd_bank_q;
        rd_issue   = 1'b0;
        clr_full   = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_state_d = R_READ;
                    rd_addr_d  = 5'd0;
                end
            end
            R_READ: begin
                rd_issue = 1'b1;
                if (rd_addr_q == 5'd31) begin
                    clr_full   = 1'b1;
                    rd_bank_d  = ~rd_bank_q;
                    rd_state_d = R_IDLE;
                end else begin
                    rd_addr_d = rd_addr_q + 5'd1;
                end
            end
        endcase
    end

    // Flags are updated from their registered values, so a same-cycle clear is not seen by the writer.
    always_comb begin
        full_d = full_q;
        if (set_full) full_d[wr_bank_q] = 1'b1;
        if (clr_full) full_d[rd_bank_q] = 1'b0;
    end

    always_comb begin
        s1_valid_d  = rd_issue;
        s1_last_d   = rd_issue && (rd_addr_q == 5'd31);
        s1_index_d  = rd_issue ? rd_index : 5'd0;
        out_valid_d = s1_valid_q;
        out_last_d  = s1_last_q;
        out_index_d = s1_index_q;
        out_i_d     = s1_valid_q ? ram_rdata_q[EW-1:DATA_WIDTH] : '0;
        out_q_d     = s1_valid_q ? ram_rdata_q[DATA_WIDTH-1:0]  : '0;
    end

    always_ff @(posedge Clk) begin
        if (wr_en) mem[{wr_bank_q, Input_index}] <= {Input_i, Input_q};
        if (rd_issue) ram_rdata_q <= mem[{rd_bank_q, rd_index}];
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_state_q  <= W_SYNC;
            rd_state_q  <= R_IDLE;
            exp_q       <= 5'd31;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            rd_addr_q   <= 5'd0;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_index_q  <= 5'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= 5'd0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            ovf_q       <= 1'b0;
            seq_q       <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            exp_q       <= exp_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            rd_addr_q   <= rd_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_index_q  <= s1_index_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_index_q <= out_index_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            ovf_q       <= ovf_d;
            seq_q       <= seq_d;
        end
    end

    assign Output_valid         = out_valid_q;
    assign Output_last          = out_last_q;
    assign Output_index         = out_index_q;
    assign Output_i             = out_i_q;
    assign Output_q             = out_q_q;
    assign Error_overflow       = ovf_q;
    assign Error_index_sequence = seq_q;

endmodule
